mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the pipeline's fetch port (IF) and data-memory port (DM).
- Arbitrates between the two ports, sequences each access through the memory's fixed read latency and returns data with a one-cycle ack pulse.
- Sits between the 5-stage pipeline core and the memory model. Supports 10-bit word-addressed memory and 32-bit data.

---
 rtl/pipe_mem_pkg.sv | 8 +
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_arb_prio.sv | 23 ++
 rtl/mem_port_arbiter.sv | 87 ++++++++
 tb/tb_mem_port_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pipe_mem_pkg.sv
// pipe_mem_pkg: shared widths, arbiter state and port-owner types for the
// pipeline memory port arbiter.
package pipe_mem_pkg;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, data port and memory port bundle.
interface mem_port_arbiter_if
    import pipe_mem_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: DM-first winner select with a starvation guard that forces
// an IF grant after ARB_LIMIT consecutive DM wins over a pending IF.
module mem_arb_prio
    import pipe_mem_pkg::*;
#(
    parameter int ARB_LIMIT = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   sample,
    input  logic   if_req,
    input  logic   dm_req,
    output owner_t win
);
    localparam int SW = $clog2(ARB_LIMIT + 2);
    logic [SW-1:0] starve_cnt;
    always_comb win = if_req && (!dm_req || starve_cnt == SW'(ARB_LIMIT)) ? OWN_IF : OWN_DM;
    // DM can only win over a pending IF while the count is below the limit, so no saturation is needed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_cnt <= '0;
        else if (sample) starve_cnt <= !if_req || win == OWN_IF ? '0 : starve_cnt + SW'(1);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data
// ports, sequencing each access through the fixed read latency.
module mem_port_arbiter
    import pipe_mem_pkg::*;
#(
    parameter int ADDR_W    = pipe_mem_pkg::ADDR_W,
    parameter int DATA_W    = pipe_mem_pkg::DATA_W,
    parameter int MEM_LAT   = 2,
    parameter int ARB_LIMIT = 3
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    arb_state_t        state;
    owner_t            owner;
    owner_t            win;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] grant_addr;
    assign grant_addr = win == OWN_IF ? bus.if_addr : bus.dm_addr;
    mem_arb_prio #(.ARB_LIMIT(ARB_LIMIT)) u_prio (
        .clk    (clk),
        .rst    (rst),
        .sample (state == IDLE),
        .if_req (bus.if_req),
        .dm_req (bus.dm_req),
        .win    (win)
    );
    // mem_we doubles as the latched write flag while in ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            wait_cnt      <= '0;
            bus.if_ack    <= 1'b0;
            bus.dm_ack    <= 1'b0;
            bus.if_rdata  <= {DATA_W{1'b0}};
            bus.dm_rdata  <= {DATA_W{1'b0}};
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.busy      <= 1'b0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.dm_ack <= 1'b0;
            bus.mem_en <= 1'b0;
            case (state)
                IDLE: if (bus.if_req || bus.dm_req) begin
                    state        <= ISSUE;
                    owner        <= win;
                    bus.busy     <= 1'b1;
                    bus.mem_en   <= 1'b1;
                    bus.mem_we   <= win == OWN_DM && bus.dm_we;
                    bus.mem_addr <= grant_addr;
                    if (win == OWN_DM) bus.mem_wdata <= bus.dm_wdata;
                end
                ISSUE: begin
                    bus.mem_we <= 1'b0;
                    if (bus.mem_we) begin
                        state      <= RESP;
                        bus.if_ack <= owner == OWN_IF;
                        bus.dm_ack <= owner == OWN_DM;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= 4'(MEM_LAT - 1);
                    end
                end
                WAIT: if (wait_cnt == 4'd0) begin
                    state <= RESP;
                    if (owner == OWN_IF) begin
                        bus.if_rdata <= bus.mem_rdata;
                        bus.if_ack   <= 1'b1;
                    end else begin
                        bus.dm_rdata <= bus.mem_rdata;
                        bus.dm_ack   <= 1'b1;
                    end
                end else wait_cnt <= wait_cnt - 4'd1;
                RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, starvation
// guard and reset abort, with a MEM_LAT=1 instance alongside.
module tb_mem_port_arbiter;
    import pipe_mem_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    mem_port_arbiter_if u0 ();
    mem_port_arbiter_if u1 ();
    mem_port_arbiter #(.MEM_LAT(2)) dut (.clk(clk), .rst(rst), .bus(u0.slave));
    mem_port_arbiter #(.MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(u1.slave));
    logic [31:0] mem [1024];
    logic [31:0] p0 [2];
    logic [31:0] p1 [1];
    logic [9:0]  exp_ord [6] = '{10'h200, 10'h201, 10'h202, 10'h100, 10'h203, 10'h204};
    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE0000 | 32'(a);
    endfunction
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
        mem[4]     <= 32'hFC000000;
        mem[10'h20] <= 32'h12345678;
    end
    // read data is valid only in the single capture cycle; other cycles carry a poison value
    always @(posedge clk) begin
        if (u0.mem_en && u0.mem_we) mem[u0.mem_addr] <= u0.mem_wdata;
        p0[0] <= u0.mem_en && !u0.mem_we ? mem[u0.mem_addr] : 32'hBAD0BAD0;
        p0[1] <= p0[0];
        p1[0] <= u1.mem_en && !u1.mem_we ? mem[u1.mem_addr] : 32'hBAD0BAD0;
    end
    assign u0.mem_rdata = p0[1];
    assign u1.mem_rdata = p1[0];
    assert property (@(posedge clk) disable iff (rst) u0.if_req && !u0.if_ack |=> u0.if_req || u0.if_ack);
    assert property (@(posedge clk) disable iff (rst) u0.dm_req && !u0.dm_ack |=> u0.dm_req || u0.dm_ack);
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int g;
        int dn;
        {u0.if_req, u0.if_addr, u0.dm_req, u0.dm_we, u0.dm_addr, u0.dm_wdata} = '0;
        {u1.if_req, u1.if_addr, u1.dm_req, u1.dm_we, u1.dm_addr, u1.dm_wdata} = '0;
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("idle", {u0.mem_en, u0.if_ack, u0.dm_ack, u0.busy}, 0);
        end
        chk("rst_outs", 32'(|{u0.if_rdata, u0.dm_rdata, u0.mem_we, u0.mem_addr, u0.mem_wdata}), 0);
        u0.if_req = 1'b1;
        u0.if_addr = 10'h004;
        tick(1);
        chk("if_mem_en", u0.mem_en, 1);
        chk("if_mem_addr", u0.mem_addr, 32'h004);
        chk("if_mem_we", u0.mem_we, 0);
        chk("if_busy", u0.busy, 1);
        tick(2);
        chk("if_ack_early", u0.if_ack, 0);
        tick(1);
        chk("if_ack", u0.if_ack, 1);
        chk("if_rdata", u0.if_rdata, 32'hFC000000);
        u0.if_req = 1'b0;
        tick(1);
        chk("if_ack_pulse", u0.if_ack, 0);
        chk("if_busy_done", u0.busy, 0);
        u0.dm_req = 1'b1;
        u0.dm_we = 1'b1;
        u0.dm_addr = 10'h010;
        u0.dm_wdata = 32'hDEADBEEF;
        tick(1);
        chk("wr_mem_en", u0.mem_en, 1);
        chk("wr_mem_we", u0.mem_we, 1);
        chk("wr_mem_addr", u0.mem_addr, 32'h010);
        chk("wr_mem_wdata", u0.mem_wdata, 32'hDEADBEEF);
        tick(1);
        chk("wr_dm_ack", u0.dm_ack, 1);
        chk("wr_mem_we_clr", u0.mem_we, 0);
        chk("wr_addr_hold", u0.mem_addr, 32'h010);
        chk("wr_if_rdata", u0.if_rdata, 32'hFC000000);
        u0.dm_we = 1'b0;
        tick(1);
        chk("rd_ack_pulse", u0.dm_ack, 0);
        tick(1);
        chk("rd_mem_en", u0.mem_en, 1);
        chk("rd_mem_we", u0.mem_we, 0);
        tick(2);
        chk("rd_dm_ack_early", u0.dm_ack, 0);
        tick(1);
        chk("rd_dm_ack", u0.dm_ack, 1);
        chk("rd_dm_rdata", u0.dm_rdata, 32'hDEADBEEF);
        chk("rd_if_rdata", u0.if_rdata, 32'hFC000000);
        u0.dm_req = 1'b0;
        tick(1);
        u0.if_req = 1'b1;
        u0.if_addr = 10'h100;
        u0.dm_req = 1'b1;
        u0.dm_addr = 10'h200;
        g = 0;
        dn = 0;
        for (int c = 0; c < 200 && (u0.if_req || u0.dm_req); c++) begin
            tick(1);
            chk("ack_overlap", u0.if_ack & u0.dm_ack, 0);
            if (u0.mem_en) begin
                if (g < 6) chk($sformatf("grant%0d", g), u0.mem_addr, exp_ord[g]);
                g++;
            end
            if (u0.if_ack) begin
                chk("starve_if_data", u0.if_rdata, pat(10'h100));
                u0.if_req = 1'b0;
            end
            if (u0.dm_ack) begin
                chk($sformatf("starve_dm_data%0d", dn), u0.dm_rdata, pat(10'h200 + dn));
                dn++;
                if (dn == 5) u0.dm_req = 1'b0;
                else u0.dm_addr = 10'(10'h200 + dn);
            end
        end
        chk("starve_done", u0.if_req | u0.dm_req, 0);
        chk("grant_count", g, 6);
        chk("dm_count", dn, 5);
        tick(1);
        u0.if_req = 1'b1;
        u0.if_addr = 10'h020;
        tick(2);
        chk("abort_busy", u0.busy, 1);
        rst = 1'b1;
        u0.if_req = 1'b0;
        tick(1);
        chk("abort_busy_clr", u0.busy, 0);
        chk("abort_ack", u0.if_ack, 0);
        chk("abort_rdata", u0.if_rdata, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("abort_no_ack", {u0.if_ack, u0.dm_ack, u0.mem_en}, 0);
        end
        u0.if_req = 1'b1;
        tick(1);
        chk("fresh_mem_en", u0.mem_en, 1);
        tick(2);
        chk("fresh_ack_early", u0.if_ack, 0);
        tick(1);
        chk("fresh_ack", u0.if_ack, 1);
        chk("fresh_rdata", u0.if_rdata, 32'h12345678);
        u0.if_req = 1'b0;
        u1.if_req = 1'b1;
        u1.if_addr = 10'h004;
        tick(1);
        chk("lat1_mem_en", u1.mem_en, 1);
        chk("lat1_mem_addr", u1.mem_addr, 32'h004);
        tick(1);
        chk("lat1_ack_early", u1.if_ack, 0);
        tick(1);
        chk("lat1_ack", u1.if_ack, 1);
        chk("lat1_rdata", u1.if_rdata, 32'hFC000000);
        u1.if_req = 1'b0;
        tick(1);
        chk("lat1_ack_pulse", u1.if_ack, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
